// File: rtl/box_motion.sv
// -----------------------------------------------------------------------------
// box_motion
//
// Per-frame motion engine for the bouncing-box screensaver. Watches the video
// timer's frame counter and, once per frame change, moves the box, bounces it
// off the screen edges and cycles its colour. An exact corner hit freezes the
// box for CORNER_HOLD_FRAMES frames while the flash output alternates.
//
// Update event: any clock edge where `frame` differs from the value seen at the
// previous update. There is no handshake; the renderer samples the registered
// outputs whenever it likes, since they only change on update edges (bounce and
// corner are single-cycle pulses on the cycle after the update edge).
//
// Ports:
//   clk        in   pixel clock, only clock
//   rst_n      in   synchronous active-low reset
//   enable     in   low: frame changes are tracked, motion is suppressed (RUN)
//   frame      in   32-bit frame counter from the video timer
//   box_x      out  box left edge
//   box_y      out  box top edge
//   color      out  colour index, 1..7
//   bounce     out  pulse: this update hit at least one edge
//   corner     out  pulse: this update hit an x edge and a y edge together
//   flash      out  alternates each frame while held after a corner hit
//   dbg_state  out  FSM state, 0 = RUN, 1 = HOLD
// -----------------------------------------------------------------------------
module box_motion #(
  parameter int SCREEN_WIDTH       = 640,
  parameter int SCREEN_HEIGHT      = 480,
  parameter int BOX_WIDTH          = 100,
  parameter int BOX_HEIGHT         = 100,
  parameter int INIT_X             = 50,
  parameter int INIT_Y             = 50,
  parameter int X_SPEED            = 2,
  parameter int Y_SPEED            = 1,
  parameter int CORNER_HOLD_FRAMES = 30
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic [31:0]                       frame,
  output logic [$clog2(SCREEN_WIDTH)-1:0]   box_x,
  output logic [$clog2(SCREEN_HEIGHT)-1:0]  box_y,
  output logic [2:0]                        color,
  output logic                              bounce,
  output logic                              corner,
  output logic                              flash,
  output logic                              dbg_state
);

  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);
  localparam int HW = $clog2(CORNER_HOLD_FRAMES + 1);

  // Limits and speeds, one bit wider than the position for the edge compares.
  localparam logic [XW:0]   XMAX_W = (XW+1)'(SCREEN_WIDTH - BOX_WIDTH);
  localparam logic [YW:0]   YMAX_W = (YW+1)'(SCREEN_HEIGHT - BOX_HEIGHT);
  localparam logic [XW:0]   XS_W   = (XW+1)'(X_SPEED);
  localparam logic [YW:0]   YS_W   = (YW+1)'(Y_SPEED);
  localparam logic [XW-1:0] XS_N   = XW'(X_SPEED);
  localparam logic [YW-1:0] YS_N   = YW'(Y_SPEED);
  localparam logic [XW-1:0] XMAX_N = XW'(SCREEN_WIDTH - BOX_WIDTH);
  localparam logic [YW-1:0] YMAX_N = YW'(SCREEN_HEIGHT - BOX_HEIGHT);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            dir_x_q, dir_x_d;   // 1 = moving towards larger coordinate
  logic            dir_y_q, dir_y_d;
  logic [2:0]      color_q, color_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            flash_q, flash_d;
  logic            bounce_q, bounce_d;
  logic            corner_q, corner_d;
  logic [31:0]     frame_prev_q, frame_prev_d;

  logic            update;
  logic            hit_x, hit_y;
  logic [XW:0]     x_sum;
  logic [YW:0]     y_sum;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    color_d      = color_q;
    hold_cnt_d   = hold_cnt_q;
    flash_d      = flash_q;
    bounce_d     = 1'b0;
    corner_d     = 1'b0;
    frame_prev_d = frame_prev_q;
    hit_x        = 1'b0;
    hit_y        = 1'b0;

    update = (frame != frame_prev_q);
    x_sum  = {1'b0, x_q} + XS_W;
    y_sum  = {1'b0, y_q} + YS_W;

    if (update) begin
      // Track every frame change, even when frozen or disabled, so a later
      // enable does not replay stale changes.
      frame_prev_d = frame;

      case (state_q)
        ST_RUN: begin
          if (enable) begin
            if (dir_x_q) begin
              if (x_sum >= XMAX_W) begin
                x_d     = XMAX_N;
                dir_x_d = 1'b0;
                hit_x   = 1'b1;
              end else begin
                x_d = x_q + XS_N;
              end
            end else begin
              if ({1'b0, x_q} <= XS_W) begin
                x_d     = '0;
                dir_x_d = 1'b1;
                hit_x   = 1'b1;
              end else begin
                x_d = x_q - XS_N;
              end
            end

            if (dir_y_q) begin
              if (y_sum >= YMAX_W) begin
                y_d     = YMAX_N;
                dir_y_d = 1'b0;
                hit_y   = 1'b1;
              end else begin
                y_d = y_q + YS_N;
              end
            end else begin
              if ({1'b0, y_q} <= YS_W) begin
                y_d     = '0;
                dir_y_d = 1'b1;
                hit_y   = 1'b1;
              end else begin
                y_d = y_q - YS_N;
              end
            end

            // A double hit still advances the colour only once; 0 is skipped.
            if (hit_x || hit_y) begin
              bounce_d = 1'b1;
              color_d  = (color_q == 3'd7) ? 3'd1 : color_q + 3'd1;
            end

            if (hit_x && hit_y) begin
              corner_d   = 1'b1;
              state_d    = ST_HOLD;
              hold_cnt_d = HW'(CORNER_HOLD_FRAMES);
              flash_d    = 1'b1;
            end
          end
        end

        ST_HOLD: begin
          // Position, direction and colour stay frozen; enable is ignored.
          hold_cnt_d = hold_cnt_q - HW'(1);
          if (hold_cnt_q == HW'(1)) begin
            state_d = ST_RUN;
            flash_d = 1'b0;
          end else begin
            flash_d = ~flash_q;
          end
        end

        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      x_q          <= XW'(INIT_X);
      y_q          <= YW'(INIT_Y);
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      color_q      <= 3'b111;
      hold_cnt_q   <= '0;
      flash_q      <= 1'b0;
      bounce_q     <= 1'b0;
      corner_q     <= 1'b0;
      // All ones so a timer that has already wrapped to 0 still updates.
      frame_prev_q <= 32'hFFFF_FFFF;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      color_q      <= color_d;
      hold_cnt_q   <= hold_cnt_d;
      flash_q      <= flash_d;
      bounce_q     <= bounce_d;
      corner_q     <= corner_d;
      frame_prev_q <= frame_prev_d;
    end
  end

  assign box_x     = x_q;
  assign box_y     = y_q;
  assign color     = color_q;
  assign bounce    = bounce_q;
  assign corner    = corner_q;
  assign flash     = flash_q;
  assign dbg_state = (state_q == ST_HOLD);

endmodule

// File: tb/tb_box_motion.sv
// -----------------------------------------------------------------------------
// tb_box_motion
//
// Two instances share the inputs: u_a uses the default start position, u_b
// starts at (536,378) so it reaches an exact corner on its second update.
// Each driven edge pushes the reference model's expected outputs for both
// instances; a monitor pops and compares one entry per clock after the edge.
// -----------------------------------------------------------------------------
module tb_box_motion;

  localparam int SW   = 640;
  localparam int SH   = 480;
  localparam int BW   = 100;
  localparam int BH   = 100;
  localparam int XS   = 2;
  localparam int YS   = 1;
  localparam int HOLD = 30;
  localparam int XMAX = SW - BW;
  localparam int YMAX = SH - BH;
  localparam int XW   = $clog2(SW);
  localparam int YW   = $clog2(SH);
  localparam int PW   = 7 + YW + XW;

  // ---------------- clock / reset / inputs ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] frame;

  always #5 clk = ~clk;

  logic [XW-1:0] a_x, b_x;
  logic [YW-1:0] a_y, b_y;
  logic [2:0]    a_color, b_color;
  logic          a_bounce, b_bounce, a_corner, b_corner;
  logic          a_flash, b_flash, a_state, b_state;

  box_motion #(.INIT_X(50), .INIT_Y(50)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame(frame),
    .box_x(a_x), .box_y(a_y), .color(a_color), .bounce(a_bounce),
    .corner(a_corner), .flash(a_flash), .dbg_state(a_state)
  );

  box_motion #(.INIT_X(536), .INIT_Y(378)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame(frame),
    .box_x(b_x), .box_y(b_y), .color(b_color), .bounce(b_bounce),
    .corner(b_corner), .flash(b_flash), .dbg_state(b_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q_a[$];
  logic [PW-1:0] exp_q_b[$];

  // ---------------- reference model ----------------
  int          init_x[2] = '{50, 536};
  int          init_y[2] = '{50, 378};
  int          m_x[2], m_y[2], m_dx[2], m_dy[2], m_color[2], m_hold[2];
  bit          m_flash[2], m_bounce[2], m_corner[2];
  logic [31:0] m_prev[2];

  function automatic logic [PW-1:0] pack(bit st, bit fl, bit co, bit bo,
                                         logic [2:0] c, logic [YW-1:0] y,
                                         logic [XW-1:0] x);
    return {st, fl, co, bo, c, y, x};
  endfunction

  function automatic logic [PW-1:0] model_pack(int k);
    return pack(m_hold[k] > 0, m_flash[k], m_corner[k], m_bounce[k],
                3'(m_color[k]), YW'(m_y[k]), XW'(m_x[k]));
  endfunction

  // Bounce one coordinate between 0 and lim.
  task automatic move_axis(inout int pos, inout int dir, input int spd,
                           input int lim, output bit hit);
    hit = 1'b0;
    if (dir > 0) begin
      if (pos + spd >= lim) begin pos = lim; dir = -1; hit = 1'b1; end
      else pos = pos + spd;
    end else begin
      if (pos <= spd) begin pos = 0; dir = 1; hit = 1'b1; end
      else pos = pos - spd;
    end
  endtask

  task automatic model_edge(input int k, input bit rst, input bit en,
                            input logic [31:0] fr);
    int px, py, ddx, ddy;
    bit hx, hy;
    m_bounce[k] = 1'b0;
    m_corner[k] = 1'b0;
    if (rst) begin
      m_x[k] = init_x[k]; m_y[k] = init_y[k];
      m_dx[k] = 1; m_dy[k] = 1;
      m_color[k] = 7; m_hold[k] = 0; m_flash[k] = 1'b0;
      m_prev[k] = 32'hFFFF_FFFF;
    end else if (fr != m_prev[k]) begin
      m_prev[k] = fr;
      if (m_hold[k] > 0) begin
        m_hold[k] = m_hold[k] - 1;
        m_flash[k] = (m_hold[k] == 0) ? 1'b0 : !m_flash[k];
      end else if (en) begin
        px = m_x[k]; ddx = m_dx[k];
        py = m_y[k]; ddy = m_dy[k];
        move_axis(px, ddx, XS, XMAX, hx);
        move_axis(py, ddy, YS, YMAX, hy);
        m_x[k] = px; m_dx[k] = ddx;
        m_y[k] = py; m_dy[k] = ddy;
        if (hx || hy) begin
          m_bounce[k] = 1'b1;
          m_color[k] = m_color[k] % 7 + 1;
        end
        if (hx && hy) begin
          m_corner[k] = 1'b1;
          m_hold[k] = HOLD;
          m_flash[k] = 1'b1;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [31:0] fr, input bit en, input bit rst);
    @(negedge clk);
    frame  = fr;
    enable = en;
    rst_n  = !rst;
    for (int k = 0; k < 2; k++) model_edge(k, rst, en, fr);
    exp_q_a.push_back(model_pack(0));
    exp_q_b.push_back(model_pack(1));
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic compare(input string name, input logic [PW-1:0] got,
                         input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h (x %0d/%0d y %0d/%0d)",
               name, $time, got, exp, got[XW-1:0], exp[XW-1:0],
               got[XW+YW-1:XW], exp[XW+YW-1:XW]);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q_a.size() > 0)
      compare("dut_a", pack(a_state, a_flash, a_corner, a_bounce, a_color, a_y, a_x),
              exp_q_a.pop_front());
    if (exp_q_b.size() > 0)
      compare("dut_b", pack(b_state, b_flash, b_corner, b_bounce, b_color, b_y, b_x),
              exp_q_b.pop_front());
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] fr;
    int          r;
    rst_n  = 1'b0;
    enable = 1'b0;
    frame  = 32'd0;

    repeat (3) step(32'd7, 1'b1, 1'b1);

    // Release with frame already at 0, then step 0..245 with random dwell.
    for (int f = 0; f <= 245; f++) begin
      step(32'(f), 1'b1, 1'b0);
      @(posedge clk); #1;
      case (f)
        0: begin
          chk("a_x_f0", a_x, 52); chk("a_y_f0", a_y, 51);
          chk("a_color_f0", a_color, 7); chk("a_bounce_f0", a_bounce, 0);
        end
        1: begin
          chk("b_x_corner", b_x, 540); chk("b_y_corner", b_y, 380);
          chk("b_bounce_corner", b_bounce, 1); chk("b_corner_corner", b_corner, 1);
          chk("b_color_corner", b_color, 1); chk("b_state_corner", b_state, 1);
          chk("b_flash_corner", b_flash, 1);
          chk("a_x_f1", a_x, 54);
        end
        2: begin
          chk("a_x_f2", a_x, 56); chk("a_y_f2", a_y, 53);
          chk("b_flash_h1", b_flash, 0); chk("b_corner_h1", b_corner, 0);
        end
        3:   begin chk("b_flash_h2", b_flash, 1); chk("b_x_h2", b_x, 540); end
        31:  begin chk("b_state_end", b_state, 0); chk("b_flash_end", b_flash, 0); end
        32:  begin chk("b_x_resume", b_x, 538); chk("b_y_resume", b_y, 379); end
        244: begin
          chk("a_x_edge", a_x, 540); chk("a_bounce_edge", a_bounce, 1);
          chk("a_color_edge", a_color, 1);
        end
        245: chk("a_x_back", a_x, 538);
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) step(32'(f), 1'b1, 1'b0);
    end

    // Random frame advances, jumps, holds, enable drops and rare resets.
    fr = 32'd246;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      fr = fr + 32'($urandom_range(2, 6));
      else if (r < 80) fr = fr + 32'd1;
      step(fr, $urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0);
    end

    // Enable low for 10 frame steps, then one enabled step.
    for (int i = 0; i < 10; i++) begin
      fr = fr + 32'd1;
      step(fr, 1'b0, 1'b0);
    end
    fr = fr + 32'd1;
    step(fr, 1'b1, 1'b0);

    // Jump 5 -> 9, then hold frame constant for 1000 cycles.
    step(32'd5, 1'b1, 1'b0);
    step(32'd9, 1'b1, 1'b0);
    repeat (1000) step(32'd9, 1'b1, 1'b0);

    // Reset coincident with a frame change while u_b is in HOLD.
    step(32'd0, 1'b1, 1'b1);
    step(32'd0, 1'b1, 1'b0);
    step(32'd1, 1'b1, 1'b0);
    step(32'd2, 1'b1, 1'b0);
    step(32'd3, 1'b1, 1'b0);
    step(32'd4, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("b_x_rst_hold", b_x, 536); chk("b_y_rst_hold", b_y, 378);
    chk("b_state_rst_hold", b_state, 0); chk("b_flash_rst_hold", b_flash, 0);
    chk("b_bounce_rst_hold", b_bounce, 0); chk("b_corner_rst_hold", b_corner, 0);
    chk("b_color_rst_hold", b_color, 7);
    step(32'd5, 1'b1, 1'b0);
    step(32'd6, 1'b1, 1'b0);

    // Let the monitor drain the last entries.
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q_a.size() + exp_q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/box_motion.md
# box_motion

Per-frame motion engine for the bouncing-box screensaver. Sits between the video timer and the pixel renderer: it consumes the timer's `frame` counter and produces the box's top-left position, its colour index, and bounce/corner status for the renderer. State advances once per frame change. A small FSM freezes and flashes the box for a fixed number of frames after an exact corner hit.

## Interface
Parameters:
- `SCREEN_WIDTH`, 640: visible width in pixels.
- `SCREEN_HEIGHT`, 480: visible height in pixels.
- `BOX_WIDTH`, 100: box width.
- `BOX_HEIGHT`, 100: box height.
- `INIT_X`, 50: reset x position.
- `INIT_Y`, 50: reset y position.
- `X_SPEED`, 2: pixels moved per frame in x, ≥1.
- `Y_SPEED`, 1: pixels moved per frame in y, ≥1.
- `CORNER_HOLD_FRAMES`, 30: frames spent in HOLD after a corner hit, ≥1.

Ports:
- `clk`  in  1: pixel clock; the block's only clock.
- `rst_n`  in  1: synchronous active-low reset.
- `enable`  in  1: when low, frame changes are tracked but no motion update occurs.
- `frame`  in  32: frame counter from the video timer.
- `box_x`  out  $clog2(SCREEN_WIDTH): box left edge.
- `box_y`  out  $clog2(SCREEN_HEIGHT): box top edge.
- `color`  out  3: colour index, never 3'b000.
- `bounce`  out  1: one-cycle pulse on any update that hit an edge.
- `corner`  out  1: one-cycle pulse on any update that hit an x edge and a y edge together.
- `flash`  out  1: high on alternate frames while in HOLD.

## Operation
- Reset values, applied on an edge with `rst_n`=0:
  - `box_x`=INIT_X, `box_y`=INIT_Y.
  - dir_x=+, dir_y=+.
  - `color`=3'b111.
  - state=RUN, hold_cnt=0.
  - `flash`=0, `bounce`=0, `corner`=0.
  - frame_prev=32'hFFFF_FFFF.
- Reset takes priority over every other event.
- Update event: an edge where `frame` != frame_prev.
  - frame_prev is loaded with `frame` on every such edge, whatever the value of `enable` or the state.
  - A jump of more than 1 in `frame` still produces exactly one update.
- Limits: XMAX = SCREEN_WIDTH−BOX_WIDTH and YMAX = SCREEN_HEIGHT−BOX_HEIGHT.
- Arithmetic is done one bit wider than the outputs, unsigned.
- RUN state, on an update with `enable`=1 (x shown; y is identical with Y_SPEED and YMAX):
  - dir + : if x+X_SPEED ≥ XMAX then x←XMAX, dir←−, hit_x=1; else x←x+X_SPEED.
  - dir − : if x ≤ X_SPEED then x←0, dir←+, hit_x=1; else x←x−X_SPEED.
  - If hit_x or hit_y: pulse `bounce` and set color ← (color==7) ? 1 : color+1. Two simultaneous hits advance the colour once.
  - If hit_x and hit_y: pulse `corner`, go to HOLD, hold_cnt←CORNER_HOLD_FRAMES, `flash`←1.
- HOLD state, on each update:
  - Position, direction and colour are frozen.
  - `flash` toggles and hold_cnt decrements.
  - When hold_cnt reaches 0: state←RUN, `flash`←0. Motion resumes at the next update, with the directions reflected at the corner.
  - HOLD counts regardless of `enable`.
- With `enable`=0 in RUN, nothing changes except frame_prev.

## Timing
- All outputs are registered.
- Latency: if `frame` changes before edge N, the new `box_x`, `box_y`, `color` and `flash` are visible after edge N, and the `bounce`/`corner` pulse is high for the cycle following edge N only.
- Outputs are constant between update events, so the renderer may sample them at any pixel.
- Reset asserted mid-HOLD returns to RUN at INIT values on that edge.
- Reset releasing with `frame`=0 (the timer has already wrapped) produces an update on the first cycle after release.

## Test plan
- Reset, then step `frame` 0,1,2 → `box_x`=52,54,56; `box_y`=51,52,53; `color`=7; no `bounce`.
- Defaults, 245 updates → `box_x`=540, dir_x flips, `bounce` pulses once, `color`=1. The next update gives `box_x`=538.
- INIT_X=536, INIT_Y=378, 2 updates → `box_x`=540, `box_y`=380; `bounce` and `corner` pulse together; `color`=1; state HOLD; `flash`=1.
  - Over the next 30 updates the position is held and `flash` alternates.
  - The following update gives `box_x`=538, `box_y`=379.
- `enable`=0 for 10 frame steps → outputs unchanged. Re-enabling and stepping once moves the box by exactly one step.
- `frame` jumps 5→9 → exactly one update. `frame` held constant for 1000 cycles → no update.
- `rst_n` low during HOLD, coincident with a frame change → INIT values, RUN state, `flash`=0, no pulses.
